// File: rtl/rr_req_arbiter_pkg.sv
// Shared definitions for the request arbiter and the downstream encoder bench.
// Package arb_pkg: FSM states, default requester count, one-hot to index helper.
package arb_pkg;

  localparam int N_DEFAULT = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Lowest set bit wins if more than one is hot; the arbiter never produces that.
  function automatic logic [3:0] onehot_to_idx(input logic [15:0] onehot);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (onehot[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_req_arbiter_if.sv
// Handshake bundle between request sources, the arbiter and the grant consumer.
interface rr_req_arbiter_if
  import arb_pkg::*;
#(
  parameter int N    = N_DEFAULT,
  parameter int IDXW = $clog2(N)
) ();

  logic [N-1:0]    req_in;
  logic            grant_ready;
  logic            grant_valid;
  logic [N-1:0]    grant_onehot;
  logic [IDXW-1:0] grant_idx;
  logic [N-1:0]    pending;
  logic            merge_pulse;

  modport master (
    output req_in,
    output grant_ready,
    input  grant_valid,
    input  grant_onehot,
    input  grant_idx,
    input  pending,
    input  merge_pulse
  );

  modport slave (
    input  req_in,
    input  grant_ready,
    output grant_valid,
    output grant_onehot,
    output grant_idx,
    output pending,
    output merge_pulse
  );

endinterface

// File: rtl/rr_req_arbiter_pick.sv
// Combinational winner selection over the pending vector.
// ARB_FIXED_PRIORITY_EN: no pointer input, lowest index always wins.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N    = N_DEFAULT,
  parameter int IDXW = $clog2(N)
) (
`ifndef ARB_FIXED_PRIORITY_EN
  input  logic [IDXW-1:0] i_ptr,
`endif
  input  logic [N-1:0]    i_pending,
  output logic [N-1:0]    o_onehot,
  output logic [IDXW-1:0] o_idx,
  output logic            o_any_req
);

`ifndef ARB_FIXED_PRIORITY_EN
  logic [N-1:0]    w_rot;
  logic [IDXW-1:0] w_off;

  // Addition modulo N, so pointer-relative positions never leave 0..N-1.
  function automatic logic [IDXW-1:0] wrapAdd(input logic [IDXW-1:0] a,
                                              input logic [IDXW-1:0] b);
    logic [IDXW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= (IDXW+1)'(N)) sum = sum - (IDXW+1)'(N);
    return sum[IDXW-1:0];
  endfunction

  always_comb begin
    w_rot = '0;
    for (int k = 0; k < N; k++) begin
      w_rot[k] = i_pending[wrapAdd(i_ptr, IDXW'(k))];
    end
    w_off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = IDXW'(k);
    end
    o_any_req = |i_pending;
    o_idx     = o_any_req ? wrapAdd(i_ptr, w_off) : '0;
    o_onehot  = '0;
    if (o_any_req) o_onehot[o_idx] = 1'b1;
  end
`else
  always_comb begin
    o_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_pending[k]) o_idx = IDXW'(k);
    end
    o_any_req = |i_pending;
    o_onehot  = '0;
    if (o_any_req) o_onehot[o_idx] = 1'b1;
  end
`endif

endmodule

// File: rtl/rr_req_arbiter.sv
// Sticky request capture plus round-robin one-hot grant under valid/ready.
// ARB_FIXED_PRIORITY_EN selects fixed lowest-index priority instead of round-robin.
module rr_req_arbiter
  import arb_pkg::*;
#(
  parameter int N    = N_DEFAULT,
  parameter int IDXW = $clog2(N)
) (
  input logic             clk,
  input logic             rst_n,
  rr_req_arbiter_if.slave bus
);

  arb_state_t      r_state;
  logic [N-1:0]    r_pending;
  logic [N-1:0]    r_onehot;
  logic [IDXW-1:0] r_idx;
  logic            r_valid;
  logic            r_merge;

  logic [N-1:0]    w_consumed;
  logic [N-1:0]    w_pickOnehot;
  logic [IDXW-1:0] w_pickIdx;
  logic            w_anyReq;

  assign w_consumed = (r_valid && bus.grant_ready) ? r_onehot : '0;

`ifndef ARB_FIXED_PRIORITY_EN
  logic [IDXW-1:0] r_ptr;
`endif

  rr_pick #(
    .N    (N),
    .IDXW (IDXW)
  ) u_pick (
`ifndef ARB_FIXED_PRIORITY_EN
    .i_ptr     (r_ptr),
`endif
    .i_pending (r_pending),
    .o_onehot  (w_pickOnehot),
    .o_idx     (w_pickIdx),
    .o_any_req (w_anyReq)
  );

  // A request landing on the bit being consumed this cycle re-arms it as a new event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_onehot  <= '0;
      r_idx     <= '0;
      r_valid   <= 1'b0;
      r_merge   <= 1'b0;
`ifndef ARB_FIXED_PRIORITY_EN
      r_ptr     <= '0;
`endif
    end else begin
      r_pending <= (r_pending & ~w_consumed) | bus.req_in;
      r_merge   <= |(bus.req_in & r_pending & ~w_consumed);
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            r_valid  <= 1'b1;
            r_onehot <= w_pickOnehot;
            r_idx    <= w_pickIdx;
            r_state  <= GRANT;
          end
        end
        GRANT: begin
          if (bus.grant_ready) begin
            r_valid  <= 1'b0;
            r_onehot <= '0;
            r_idx    <= '0;
            r_state  <= IDLE;
`ifndef ARB_FIXED_PRIORITY_EN
            r_ptr    <= (r_idx == IDXW'(N - 1)) ? '0 : r_idx + IDXW'(1);
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.grant_valid  = r_valid;
  assign bus.grant_onehot = r_onehot;
  assign bus.grant_idx    = r_idx;
  assign bus.pending      = r_pending;
  assign bus.merge_pulse  = r_merge;

endmodule

// File: doc/rr_req_arbiter.md
Name: rr_req_arbiter

Overview:
- Upstream stage of the 4-to-2 encoder.
- Captures asynchronous-rate request events from N sources into sticky pending bits.
- Picks one winner at a time by round-robin and presents it as a guaranteed one-hot vector plus a binary index under a valid/ready handshake.
- Guarantees the downstream encoder never sees more than one hot bit.

Parameters:
- N, 4, number of requesters; legal values are 2..16.
- IDXW, $clog2(N) (2 for N=4), width of the binary grant index.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- req_in  input  N  request events; each bit is sampled every cycle.
- grant_ready  input  1  the consumer accepts the current grant.
- grant_valid  output  1  grant_onehot and grant_idx are valid.
- grant_onehot  output  N  one-hot winner; all zeros when grant_valid=0.
- grant_idx  output  IDXW  binary index of the winner; zero when grant_valid=0.
- pending  output  N  registered pending request bits.
- merge_pulse  output  1  one-cycle pulse when a request hits an already-pending bit.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n).
  - While rst_n=0, all of these are 0: pending, grant_valid, grant_onehot, grant_idx, merge_pulse, rr pointer. State is IDLE.
  - Reset mid-grant discards the grant and all pending events immediately. No grant appears after release until new req_in arrives.
- Pending update, every cycle:
  - pending <= (pending & ~consumed) | req_in.
  - consumed = grant_onehot when grant_valid & grant_ready, else 0.
  - If req_in sets a bit in the same cycle that bit is consumed, the bit stays pending (treated as a new event).
- merge_pulse <= |(req_in & pending & ~consumed), registered, high for one cycle.
- FSM has two states, IDLE and GRANT.
  - IDLE: if pending != 0, compute the winner and register grant_onehot/grant_idx, set grant_valid=1, and go to GRANT. Otherwise stay in IDLE.
  - GRANT: while grant_ready=0, hold grant_valid, grant_onehot and grant_idx stable. The pending bits of other sources may still change.
  - GRANT on grant_ready=1: the handshake completes that cycle. Next cycle grant_valid=0, grant_onehot=0, grant_idx=0, state IDLE. The rr pointer becomes (grant_idx+1) mod N.
- Latency and throughput:
  - A req_in pulse at edge t makes pending visible after t. grant_valid rises after edge t+1, a 2-cycle minimum.
  - Sustained throughput is one grant every 2 cycles; the IDLE bubble is intentional.
- Round-robin search:
  - Scans pending starting at the pointer, ascending, wrapping from N-1 to 0. The first set bit wins.
  - The pointer wraps modulo N. With N not a power of 2, pointer values of N or more never occur.
- grant_ready while grant_valid=0 is ignored.

Optional Feature:
- Macro: ARB_FIXED_PRIORITY_EN.
- Defined: the rr pointer is removed. The winner is always the lowest-indexed pending bit (index 0 has highest priority). All other behaviour is unchanged.
- Undefined: round-robin as specified above.

Decomposition:
- Shared package arb_pkg:
  - FSM state typedef (IDLE, GRANT).
  - Default N constant.
  - Function onehot_to_idx, also usable by the encoder bench.
- Sub-module rr_pick: combinational. Inputs are pending[N] and ptr[IDXW]; outputs are onehot[N], idx[IDXW] and any_req. It contains the rotate/scan logic and the fixed-priority variant under ARB_FIXED_PRIORITY_EN.

Test Plan:
1. Reset: hold rst_n=0 with req_in=1111 -> all outputs 0. Release, hold req_in=0 -> no grant ever.
2. Single request: req_in=0001 for 1 cycle, grant_ready=1 -> grant_valid high 2 cycles later with onehot=0001, idx=00, accepted in 1 cycle. pending returns to 0000.
3. Round-robin wrap: req_in=1111 for 1 cycle, grant_ready=1 -> grants 0001, 0010, 0100, 1000 (idx 0..3) every 2 cycles. Next req_in=0001 grants idx 0 (pointer wrapped).
4. Backpressure: pending=0110, grant_ready=0 for 5 cycles -> onehot=0010 held stable for all 5. Raising ready accepts it, then 0100 is granted.
5. Merge and collision:
   - req_in=0100 while bit 2 is pending and not granted -> merge_pulse for 1 cycle, only one grant for bit 2.
   - req_in=0100 in the accept cycle of bit 2 -> bit 2 stays pending and is granted again.
6. Reset mid-grant and fixed priority:
   - Drop rst_n during GRANT with pending=1010 -> outputs 0 asynchronously.
   - With ARB_FIXED_PRIORITY_EN, re-asserting 0001 each cycle together with 1000 -> bit 0 always wins.
